// File: rtl/pool_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : pool_pkg                                                       |
// | Purpose   : Shared types, default fixed-point widths and the signed max    |
// |             helper for the streaming 2x2 pooling stage.                    |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package pool_pkg;

  localparam int c_DEF_INTEGER_BITS     = 9;
  localparam int c_DEF_FIXED_POINT_BITS = 4;

  // Working width of max_signed; operands are sign-extended into it.
  localparam int c_ARITH_W = 32;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_t;

  typedef enum logic [1:0] {
    EVEN_ROW = 2'd0,
    ODD_ROW  = 2'd1,
    DONE     = 2'd2
  } pool_state_t;

  function automatic logic signed [c_ARITH_W-1:0] max_signed(
    input logic signed [c_ARITH_W-1:0] a,
    input logic signed [c_ARITH_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_row_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : pool_row_buffer                                                |
// | Purpose   : Half-width row store holding horizontal pair results of the    |
// |             even row until the matching odd row arrives.                   |
// | Ports     : i_clk      - clock                                             |
// |             i_wr_en    - synchronous write enable                          |
// |             i_wr_addr  - write entry                                       |
// |             i_wr_data  - pair result to store                              |
// |             i_rd_addr  - read entry (asynchronous read)                    |
// |             o_rd_data  - stored pair result                                |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module pool_row_buffer #(
  parameter int  DEPTH  = 256,
  parameter int  WIDTH  = 14,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  // Storage is deliberately not reset: every entry is rewritten by the even
  // row before the odd row reads it.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/pool_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : pool_stream_ctrl                                               |
// | Purpose   : Streaming 2x2 stride-2 max/average pooling of a raster pixel   |
// |             stream with valid/ready on both sides.                         |
// | Ports     : i_clk, i_rst        - clock, async active-high reset          |
// |             i_mode              - 0 max, 1 average (sampled at frame start)|
// |             i_data/_valid, o_data_ready - input stream                     |
// |             o_data/_valid, i_ready      - pooled output stream             |
// |             o_intr              - pulse after last pooled pixel is taken   |
// | Options   : POOL_RELU_EN - clamp negative pooled results to zero           |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module pool_stream_ctrl
  import pool_pkg::*;
#(
  parameter int  INTEGER_BITS     = c_DEF_INTEGER_BITS,
  parameter int  FIXED_POINT_BITS = c_DEF_FIXED_POINT_BITS,
  parameter int  IMG_W            = 512,
  parameter int  IMG_H            = 512,
  localparam int DATA_W           = INTEGER_BITS + FIXED_POINT_BITS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_ready,
  output logic              o_intr
);

  localparam int PAIR_W = DATA_W + 1;
  localparam int SUM_W  = DATA_W + 2;
  localparam int HALF_W = IMG_W / 2;
  localparam int COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int ADDR_W = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_H - 1);

  if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_chk_img_w
    $error("pool_stream_ctrl: IMG_W must be even and >= 2");
  end
  if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_chk_img_h
    $error("pool_stream_ctrl: IMG_H must be even and >= 2");
  end
  if (SUM_W > c_ARITH_W) begin : g_chk_data_w
    $error("pool_stream_ctrl: sample width too large for max_signed");
  end

  pool_state_t       state_q, state_d;
  pool_mode_t        mode_q, mode_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] pair_q, pair_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              intr_q, intr_d;

  logic                        w_accept;
  logic                        w_handshake;
  logic                        w_buf_we;
  logic [ADDR_W-1:0]           w_buf_addr;
  logic [PAIR_W-1:0]           w_b;
  logic [PAIR_W-1:0]           w_p;
  logic [PAIR_W-1:0]           w_pair_sum;
  logic signed [c_ARITH_W-1:0] w_pair_max;
  logic signed [c_ARITH_W-1:0] w_win_max;
  logic [SUM_W-1:0]            w_win_sum;
  logic [DATA_W-1:0]           w_win;
  logic [DATA_W-1:0]           w_result;
  logic                        w_unused;

  assign o_data_ready = ~valid_q | i_ready;
  assign w_accept     = i_data_valid & o_data_ready;
  assign w_handshake  = valid_q & i_ready;
  assign w_buf_addr   = ADDR_W'(col_q >> 1);

  // Horizontal pair: stored even-column pixel against the current odd one.
  assign w_pair_max = max_signed(c_ARITH_W'($signed(pair_q)), c_ARITH_W'($signed(i_data)));
  assign w_pair_sum = PAIR_W'($signed(pair_q)) + PAIR_W'($signed(i_data));
  assign w_p        = (mode_q == POOL_AVG) ? w_pair_sum : w_pair_max[PAIR_W-1:0];

  // Vertical combine with the pair result saved from the even row. Dropping
  // the two low bits of the sum is an arithmetic shift, i.e. floor(sum/4).
  assign w_win_max = max_signed(c_ARITH_W'($signed(w_b)), c_ARITH_W'($signed(w_p)));
  assign w_win_sum = SUM_W'($signed(w_b)) + SUM_W'($signed(w_p));
  assign w_win     = (mode_q == POOL_AVG) ? w_win_sum[SUM_W-1:2] : w_win_max[DATA_W-1:0];

`ifdef POOL_RELU_EN
  assign w_result = w_win[DATA_W-1] ? '0 : w_win;
`else
  assign w_result = w_win;
`endif

  assign w_unused = ^{w_pair_max[c_ARITH_W-1:PAIR_W], w_win_max[c_ARITH_W-1:DATA_W],
                      w_win_sum[1:0]};

  pool_row_buffer #(
    .DEPTH (HALF_W),
    .WIDTH (PAIR_W)
  ) u_row_buffer (
    .i_clk     (i_clk),
    .i_wr_en   (w_buf_we),
    .i_wr_addr (w_buf_addr),
    .i_wr_data (w_p),
    .i_rd_addr (w_buf_addr),
    .o_rd_data (w_b)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    col_d    = col_q;
    row_d    = row_q;
    pair_d   = pair_q;
    data_d   = data_q;
    valid_d  = valid_q & ~i_ready;
    intr_d   = 1'b0;
    w_buf_we = 1'b0;
    unique case (state_q)
      EVEN_ROW, ODD_ROW: begin
        if (w_accept) begin
          if (!col_q[0]) begin
            pair_d = i_data;
            if ((state_q == EVEN_ROW) && (row_q == '0) && (col_q == '0)) begin
              mode_d = pool_mode_t'(i_mode);
            end
          end else if (state_q == EVEN_ROW) begin
            w_buf_we = 1'b1;
          end else begin
            data_d  = w_result;
            valid_d = 1'b1;
          end
          if (col_q == c_COL_LAST) begin
            col_d = '0;
            if (state_q == EVEN_ROW) begin
              state_d = ODD_ROW;
              row_d   = row_q + ROW_W'(1);
            end else if (row_q == c_ROW_LAST) begin
              state_d = DONE;
            end else begin
              state_d = EVEN_ROW;
              row_d   = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      DONE: begin
        // The final result is always pending here, so an input beat can only
        // be taken together with it; such a beat opens the next frame.
        if (w_handshake) begin
          intr_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = EVEN_ROW;
          if (w_accept) begin
            pair_d = i_data;
            mode_d = pool_mode_t'(i_mode);
            col_d  = COL_W'(1);
          end
        end
      end
      default: state_d = EVEN_ROW;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= EVEN_ROW;
      mode_q  <= POOL_MAX;
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      intr_q  <= intr_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_intr       = intr_q;

endmodule
`default_nettype wire

// File: doc/pool_stream_ctrl.md
Name: pool_stream_ctrl

Overview:
- Streaming 2x2, stride-2 pooling stage placed directly after the convolution output.
- Consumes one signed fixed-point pixel per accepted beat in raster order and emits one pooled pixel per 2x2 window.
- Supports runtime max/average mode and full valid/ready backpressure.
- Replaces the four-line-buffer pool control with a single half-width row buffer and an in-block pooling datapath.

Parameters:
- INTEGER_BITS, 9, integer bits of the signed fixed-point sample
- FIXED_POINT_BITS, 4, fractional bits; DATA_W = INTEGER_BITS+FIXED_POINT_BITS
- IMG_W, 512, input pixels per row; must be even, >=2; elaboration error otherwise
- IMG_H, 512, input rows per frame; must be even, >=2; elaboration error otherwise

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_mode  in  1  0 = max pool, 1 = average pool; sampled at frame start
- i_data  in  DATA_W  convolved pixel, signed two's complement
- i_data_valid  in  1  upstream valid
- o_data_ready  out  1  upstream ready
- o_data  out  DATA_W  pooled pixel, signed two's complement
- o_data_valid  out  1  downstream valid
- i_ready  in  1  downstream ready
- o_intr  out  1  one-cycle pulse when the last pooled pixel of a frame is accepted downstream

Behaviour:
- Reset values: o_data=0, o_data_valid=0, o_intr=0, state=EVEN_ROW, col=0, row=0, mode_q=0.
- Reset mid-frame discards all partial data. Row-buffer contents are don't-care after reset.
- Accept rule: a beat is accepted when i_data_valid & o_data_ready.
  - o_data_ready = ~o_data_valid | i_ready. This is combinational and has no dependence on i_data_valid.
- Counters:
  - col counts 0..IMG_W-1 and wraps to 0 at the end of a row.
  - row increments on col wrap and counts 0..IMG_H-1.
- Mode: mode_q <= i_mode when a beat is accepted with row=0 and col=0. Mode changes mid-frame are ignored.
- Pair register: on an even col, the pixel is captured in pair_q. On an odd col, the pair result P is formed from pair_q and i_data:
  - max mode: P = signed max
  - avg mode: P = sign-extended sum, DATA_W+1 bits
- State EVEN_ROW (even row index):
  - On an odd col, write P to row buffer entry col>>1.
  - On the last accept of the row, go to ODD_ROW.
- State ODD_ROW:
  - On an odd col, read buffer entry col>>1 combinationally as B.
  - Form the window result:
    - max mode: max(B,P)
    - avg mode: (B+P), DATA_W+2 bits, arithmetic shift right 2, i.e. truncation toward negative infinity
  - Load the result into o_data and set o_data_valid in the same clock edge.
  - On the last accept of the row:
    - if row = IMG_H-1, go to DONE
    - otherwise go to EVEN_ROW
- State DONE:
  - o_data_ready follows the same rule.
  - When the final output is accepted (o_data_valid & i_ready), pulse o_intr for one cycle, clear row and col, and go to EVEN_ROW.
  - Input beats arriving in DONE are accepted only after the final output is taken. They belong to the next frame.
- Output register:
  - Latency from accepting the 4th window pixel to o_data_valid=1 is 1 cycle.
  - o_data is held stable while o_data_valid & ~i_ready.
  - o_data_valid clears on handshake unless a new result loads in the same cycle.
- Throughput: 1 input pixel per cycle when downstream is always ready. Output rate is one pixel per 4 input pixels.
- Arithmetic: no saturation is needed. Max is exact, and the average of 4 values always fits in DATA_W.

Optional Feature:
- Macro: POOL_RELU_EN
- Defined: the pooled result is clamped to 0 when negative, before it is loaded into o_data. This applies in both modes.
- Undefined: signed results pass unchanged.

Decomposition:
- Shared package pool_pkg:
  - pool_mode_t (POOL_MAX=0, POOL_AVG=1)
  - pool_state_t (EVEN_ROW, ODD_ROW, DONE)
  - default INTEGER_BITS and FIXED_POINT_BITS constants
  - a max_signed function
- Sub-module pool_row_buffer:
  - IMG_W/2 entries x (DATA_W+1) bits
  - one synchronous write port, one asynchronous read port
  - no reset on storage

Test Plan:
- IMG_W=4, IMG_H=4, max mode, rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} -> outputs 6,8,14,16; o_intr one pulse after 16 is accepted.
- Same input, avg mode -> outputs 3,5,11,13 (exact: 3.5→3, 5.5→5, 11.5→11, 13.5→13 in integer view).
- Avg mode, window {-1,-2,-3,-4} (raw values, FIXED_POINT_BITS=4) -> raw output -3 (floor of -2.5), not -2.
- Max mode with window {-5,-7,-9,-3}:
  - without POOL_RELU_EN -> -3
  - with POOL_RELU_EN -> 0
- i_ready held low for 5 cycles while o_data_valid=1 -> o_data stable, o_data_ready=0, no input lost; all 4 outputs correct after release.
- Assert i_rst mid-row-1 -> all outputs go 0 immediately; a fresh 4x4 frame then yields the correct 4 outputs. Toggling i_mode mid-frame does not change that frame's mode.
